// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   RV32I load/store engine in front of a single-ported word memory that has a
//   combinational read path. Sub-word stores are done as read-modify-write:
//   the addressed word is read, one lane is replaced, and the word is written
//   back.
//
//   Parameters
//     WORDS            : size of the attached memory in 32-bit words; any
//                        access with word index >= WORDS faults.
//
//   Configuration macro
//     LSU_MISALIGN_TRAP_EN : when defined, halfword accesses with address[0]=1
//                        and word accesses with address[1:0]!=0 fault. When
//                        undefined, the address bits below natural alignment
//                        are ignored.
//
//   Ports
//     clk, reset        : clock and synchronous active-high reset
//     req_valid/ready   : request handshake (ready only while idle)
//     req_write         : 1 = store, 0 = load
//     req_funct3        : RV32I width code (B/H/W/BU/HU)
//     req_address       : byte address
//     req_wdata         : store data, sub-word data in the low bits
//     resp_valid/ready  : response handshake
//     resp_rdata        : extended load data, 0 for stores and faults
//     resp_fault        : access was rejected, memory untouched
//     mem_address       : word-aligned memory address
//     mem_write_data    : word to write
//     mem_write_enable  : word write strobe
//     mem_data          : combinational read word from memory
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_fault_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;

  // Request fields needed after acceptance; the word address lives in
  // mem_address_q, and full-word store data is consumed at acceptance.
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        accept;
  logic        fault_d;
  logic [31:0] load_d;
  logic [31:0] merge_d;

  function automatic logic is_fault(input logic        wr,
                                    input logic [2:0]  f3,
                                    input logic [31:0] a);
    logic f;
    f = 1'b0;
    case (f3)
      3'b011, 3'b110, 3'b111: f = 1'b1;
      default: f = 1'b0;
    endcase
    // There is no unsigned store.
    if (wr && f3[2]) f = 1'b1;
    if ({2'b00, a[31:2]} >= 32'(WORDS)) f = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'b01 && a[0]) f = 1'b1;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) f = 1'b1;
`endif
    return f;
  endfunction

  // Lane selection uses address[1] only for halfwords, so an unaligned
  // halfword without the trap reads the aligned half containing it.
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w,
                                              input logic [15:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = w;
    if (f3[1:0] == 2'b00) begin
      r[{lane, 3'b000} +: 8] = wd[7:0];
    end else if (lane[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  assign accept = req_valid & req_ready_q;

  always_comb begin
    fault_d = is_fault(req_write, req_funct3, req_address);
    load_d  = load_extend(mem_data, funct3_q, lane_q);
    merge_d = store_merge(mem_data, wdata_q, funct3_q, lane_q);
  end

  // Request capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q  <= req_write;
      funct3_q <= req_funct3;
      lane_q   <= req_address[1:0];
      wdata_q  <= req_wdata[15:0];
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_fault_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
      mem_address_q <= 32'h0;
      mem_wdata_q   <= 32'h0;
      mem_we_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            if (fault_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else begin
              mem_address_q <= {req_address[31:2], 2'b00};
              if (req_write && req_funct3 == 3'b010) begin
                state_q     <= WRITE;
                mem_wdata_q <= req_wdata;
                mem_we_q    <= 1'b1;
              end else begin
                state_q <= READ;
              end
            end
          end
        end
        READ: begin
          if (write_q) begin
            state_q     <= WRITE;
            mem_wdata_q <= merge_d;
            mem_we_q    <= 1'b1;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= load_d;
          end
        end
        WRITE: begin
          state_q      <= RESP;
          mem_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'h0;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          mem_we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_fault     = resp_fault_q;
  assign resp_rdata     = resp_rdata_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_wdata_q;
  // The strobe is a register, so reset asserted during WRITE must still
  // suppress it in that same cycle.
  assign mem_write_enable = mem_we_q & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_data;

  load_store_unit #(.WORDS(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_address      (req_address),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_data         (mem_data)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on rising edge.
  logic [31:0] mem [0:63];
  logic        preload;
  int          wr_count;
  logic [31:0] last_waddr;
  logic [31:0] last_wdata;

  assign mem_data = mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
      mem[0]     <= 32'h8070_F0FF;
      mem[1]     <= 32'h1122_3344;
      mem[63]    <= 32'hCAFE_F00D;
      wr_count   <= 0;
      last_waddr <= 32'h0;
      last_wdata <= 32'h0;
    end else if (mem_write_enable) begin
      mem[mem_address[7:2]] <= mem_write_data;
      wr_count   <= wr_count + 1;
      last_waddr <= mem_address;
      last_wdata <= mem_write_data;
    end
  end

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    bit        wr;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] exp_rdata;
    bit        exp_fault;
    int        exp_lat;
    int        exp_nwr;
    bit [31:0] exp_waddr;
    bit [31:0] exp_wword;
    int        hold;
  } vec_t;

  vec_t vq[$];

  task automatic add(input vec_t v);
    vq.push_back(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".req_ready"},  32'(req_ready), 32'd1);
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".resp_fault"}, 32'(resp_fault), 32'd0);
    chk({tag, ".resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, ".mem_address"}, mem_address, 32'h0);
    chk({tag, ".mem_write_data"}, mem_write_data, 32'h0);
    chk({tag, ".mem_we"}, 32'(mem_write_enable), 32'd0);
  endtask

  // One transaction: drive, accept, measure latency, hold, consume.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    int    lat;
    int    wr0;
    bit    got;
    logic [31:0] rd;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    wr0         = wr_count;
    req_write   = v.wr;
    req_funct3  = v.f3;
    req_address = v.addr;
    req_wdata   = v.wdata;
    req_valid   = 1'b1;
    resp_ready  = 1'b0;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (resp_valid) got = 1'b1;
    end
    if (!got) begin
      chk({tag, ".resp_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, ".latency"}, lat, v.exp_lat);
    chk({tag, ".rdata"}, resp_rdata, v.exp_rdata);
    chk({tag, ".fault"}, 32'(resp_fault), 32'(v.exp_fault));
    rd = resp_rdata;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
      chk({tag, ".hold_rdata"}, resp_rdata, rd);
    end
    chk({tag, ".writes"}, wr_count - wr0, v.exp_nwr);
    if (v.exp_nwr == 1) begin
      chk({tag, ".waddr"}, last_waddr, v.exp_waddr);
      chk({tag, ".wdata"}, last_wdata, v.exp_wword);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".idle_valid"}, 32'(resp_valid), 32'd0);
  endtask

  // SH at 0x4, then reset in READ (abort_at=1) or WRITE (abort_at=2).
  task automatic reset_abort(input int abort_at);
    string tag;
    int    wr0;
    int    seen;
    logic [31:0] w1;
    tag = $sformatf("rst_abort%0d", abort_at);
    @(negedge clk);
    wr0         = wr_count;
    w1          = mem[1];
    req_write   = 1'b1;
    req_funct3  = 3'b001;
    req_address = 32'h4;
    req_wdata   = 32'h0000_7777;
    req_valid   = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < abort_at; c++) @(negedge clk);
    if (abort_at == 2) chk({tag, ".we_before"}, 32'(mem_write_enable), 32'd1);
    reset = 1'b1;
    #1 chk({tag, ".we_in_reset"}, 32'(mem_write_enable), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check_reset_outputs(tag);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk({tag, ".no_resp"}, seen, 0);
    chk({tag, ".no_write"}, wr_count - wr0, 0);
    chk({tag, ".mem_word"}, mem[1], w1);
  endtask

  initial begin
    reset       = 1'b1;
    preload     = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_funct3  = 3'b000;
    req_address = 32'h0;
    req_wdata   = 32'h0;
    resp_ready  = 1'b0;

    //   wr  f3      addr         wdata          rdata          flt lat nwr waddr   wword          hold
    add('{1'b0, 3'b000, 32'h0000_0001, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, 0, 32'h0, 32'h0, 0});
    add('{1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_00F0, 1'b0, 2, 0, 32'h0, 32'h0, 0});
    add('{1'b0, 3'b001, 32'h0000_0000, 32'h0, 32'hFFFF_F0FF, 1'b0, 2, 0, 32'h0, 32'h0, 0});
    add('{1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h0000_8070, 1'b0, 2, 0, 32'h0, 32'h0, 0});
    add('{1'b0, 3'b000, 32'h0000_0003, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0, 32'h0, 32'h0, 0});
    add('{1'b0, 3'b100, 32'h0000_0002, 32'h0, 32'h0000_0070, 1'b0, 2, 0, 32'h0, 32'h0, 0});
    add('{1'b0, 3'b010, 32'h0000_0004, 32'h0, 32'h1122_3344, 1'b0, 2, 0, 32'h0, 32'h0, 0});
    add('{1'b1, 3'b000, 32'h0000_0006, 32'h0000_00AB, 32'h0, 1'b0, 3, 1, 32'h4, 32'h11AB_3344, 0});
    add('{1'b0, 3'b010, 32'h0000_0004, 32'h0, 32'h11AB_3344, 1'b0, 2, 0, 32'h0, 32'h0, 0});
    add('{1'b1, 3'b001, 32'h0000_0004, 32'h1234_5678, 32'h0, 1'b0, 3, 1, 32'h4, 32'h11AB_5678, 0});
    add('{1'b0, 3'b010, 32'h0000_0004, 32'h0, 32'h11AB_5678, 1'b0, 2, 0, 32'h0, 32'h0, 0});
    add('{1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 32'h8, 32'hDEAD_BEEF, 4});
    add('{1'b0, 3'b010, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0, 32'h0, 0});
    add('{1'b1, 3'b000, 32'h0000_0100, 32'h0000_00AB, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, 0});
    add('{1'b1, 3'b101, 32'h0000_0000, 32'h0000_1234, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, 0});
    add('{1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, 2});
    add('{1'b1, 3'b111, 32'h0000_0004, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, 0});
    add('{1'b0, 3'b010, 32'h0000_00FC, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 0, 32'h0, 32'h0, 0});
    add('{1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, 0});
    add('{1'b1, 3'b000, 32'h0000_0007, 32'hFFFF_FF55, 32'h0, 1'b0, 3, 1, 32'h4, 32'h55AB_5678, 0});
    add('{1'b1, 3'b001, 32'h0000_0006, 32'h0000_BEEF, 32'h0, 1'b0, 3, 1, 32'h4, 32'hBEEF_5678, 0});
    add('{1'b0, 3'b010, 32'h0000_0004, 32'h0, 32'hBEEF_5678, 1'b0, 2, 0, 32'h0, 32'h0, 0});
`ifdef LSU_MISALIGN_TRAP_EN
    add('{1'b0, 3'b001, 32'h0000_0003, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, 0});
    add('{1'b0, 3'b010, 32'h0000_0002, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, 0});
    add('{1'b0, 3'b101, 32'h0000_0001, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, 0});
    add('{1'b1, 3'b010, 32'h0000_0009, 32'h0102_0304, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, 0});
    add('{1'b0, 3'b010, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0, 32'h0, 0});
`else
    add('{1'b0, 3'b001, 32'h0000_0003, 32'h0, 32'hFFFF_8070, 1'b0, 2, 0, 32'h0, 32'h0, 0});
    add('{1'b0, 3'b010, 32'h0000_0002, 32'h0, 32'h8070_F0FF, 1'b0, 2, 0, 32'h0, 32'h0, 0});
    add('{1'b0, 3'b101, 32'h0000_0001, 32'h0, 32'h0000_F0FF, 1'b0, 2, 0, 32'h0, 32'h0, 0});
    add('{1'b1, 3'b010, 32'h0000_0009, 32'h0102_0304, 32'h0, 1'b0, 2, 1, 32'h8, 32'h0102_0304, 0});
    add('{1'b0, 3'b010, 32'h0000_0008, 32'h0, 32'h0102_0304, 1'b0, 2, 0, 32'h0, 32'h0, 0});
`endif

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset   = 1'b0;
    preload = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

    reset_abort(1);
    reset_abort(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter WORDS, default 64, size of the attached word memory in 32-bit words; range limit for accesses.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  unit accepts a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_address  input  32  byte address.
REQ-009 req_wdata  input  32  store data; sub-word data in the low bits.
REQ-010 resp_valid  output  1  response present.
REQ-011 resp_ready  input  1  consumer takes the response.
REQ-012 resp_rdata  output  32  extended load result; 0 for stores and faults.
REQ-013 resp_fault  output  1  access faulted; no memory write occurred.
REQ-014 mem_address  output  32  word-aligned address to the data memory, low 2 bits always 00.
REQ-015 mem_write_data  output  32  full word to write.
REQ-016 mem_write_enable  output  1  word write strobe.
REQ-017 mem_data  input  32  combinational read word from the data memory.

Function
REQ-018 FSM states: IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-019 Acceptance (req_valid & req_ready) latches write, funct3, address and wdata; the latched values drive all later states.
REQ-020 From IDLE on accept: a fault goes to RESP; a load, SB or SH goes to READ; SW goes to WRITE.
REQ-021 READ lasts 1 cycle and captures mem_data; a load then goes to RESP, a sub-word store goes to WRITE.
REQ-022 WRITE lasts 1 cycle with mem_write_enable = 1, then goes to RESP; mem_write_enable = 0 in all other states and in any cycle with reset = 1.
REQ-023 RESP holds resp_valid and the data until resp_ready = 1, then goes to IDLE; a new request cannot be accepted in the same cycle.
REQ-024 Latency from accept to resp_valid: load 2 cycles, SW 2 cycles, SB/SH 3 cycles, fault 1 cycle.
REQ-025 Byte lane = address[1:0]; halfword lane = address[1].
REQ-026 Loads: LB/LH sign-extend the selected lane, LBU/LHU zero-extend it, LW returns the word.
REQ-027 SB/SH replace only the selected lane of the captured word with wdata[7:0] or wdata[15:0]; all other bytes are preserved.
REQ-028 Faults:
  - funct3 011, 110 or 111;
  - a store with funct3 100 or 101;
  - word index address[31:2] >= WORDS.
REQ-029 A faulting access sets resp_fault = 1 and resp_rdata = 0, and performs no memory access.

Reset
REQ-030 On reset: state = IDLE, req_ready = 1, resp_valid = 0, resp_fault = 0, resp_rdata = 0, mem_address = 0, mem_write_data = 0, mem_write_enable = 0.
REQ-031 Reset in any state, including mid read-modify-write, aborts the operation; no write occurs and no response is issued.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN controls misaligned-access handling.
  - Defined: H/HU with address[0] = 1, or W with address[1:0] != 00, faults per REQ-029.
  - Undefined: the low address bits below natural alignment are ignored. H uses address[1] only; W uses lane 0.

Verification
REQ-033 Memory word 0 = 0x8070_F0FF. LB at 0x1 -> resp_rdata 0xFFFF_FFF0 two cycles after accept. LBU at 0x1 -> 0x0000_00F0.
REQ-034 Memory word 1 = 0x1122_3344. SB 0xAB at 0x6 -> exactly one write, mem_address 0x4, mem_write_data 0x11AB_3344, resp_valid 3 cycles after accept.
REQ-035 SW 0xDEAD_BEEF at 0x8 with resp_ready held 0 for 4 cycles -> resp_valid held and req_ready 0 throughout; a later LW at 0x8 returns 0xDEAD_BEEF.
REQ-036 LH at 0x3:
  - with LSU_MISALIGN_TRAP_EN: resp_fault 1 after 1 cycle, no memory access;
  - without it: returns the sign-extended upper half of word 0.
REQ-037 SB at 0x100 with WORDS = 64, and a store with funct3 101 -> each gives resp_fault 1 with mem_write_enable never asserted.
REQ-038 SH started, then reset asserted during READ or WRITE -> no write, next cycle in IDLE with all outputs at reset values.
